mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single Memoria32 instance between the UP instruction-fetch path (read-only) and the UP load/store path (read/write). It sits between the processor control unit and Memoria32, serialises accesses, and drives the memory's raddress/waddress/Datain/Wr pins. Fairness is round-robin on contention. It tolerates a configurable synchronous read latency.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between requesters, arbiter and Memoria32
//
// Purpose: groups the fetch port, load/store port and memory pins shared by
// mem_port_arbiter into one interface.
//   slave  modport : the arbiter's view (requests and mem_rdata in; acks,
//                    rdata and memory pins out)
//   master modport : the environment's view (processor requesters plus memory)
// Signals:
//   if_req/if_addr/if_ack/if_rdata            instruction fetch port (read only)
//   d_req/d_we/d_addr/d_wdata/d_ack/d_rdata   load/store port
//   mem_raddr/mem_waddr/mem_wdata/mem_wr      to Memoria32
//   mem_rdata                                 from Memoria32

interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_raddr, mem_waddr, mem_wdata, mem_wr,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one Memoria32 between fetch and load/store
//
// Purpose: serialises instruction-fetch reads and data reads/writes onto a
// single synchronous memory. Round-robin on contention, IF wins the first tie
// after reset. Reads wait RD_LAT cycles (legal 1..4) after the address is
// registered before mem_rdata is captured. Every output is a flop.
// Ports:
//   clk   in  rising-edge clock
//   nrst  in  asynchronous active-low reset; aborts any transaction in flight
//   bus   slave modport of mem_port_arbiter_if (requester ports + memory pins)

module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                nrst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  state_t        state;
  state_t        state_next;
  owner_t        owner;
  owner_t        last_grant;
  logic [2:0]    cnt;

  logic          if_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic [AW-1:0] mem_raddr_q;
  logic [AW-1:0] mem_waddr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_wr_q;

  logic          if_elig;
  logic          d_elig;
  logic          grant_if;
  logic          grant_d;
  logic          rd_done;

  // Address LSBs are dropped: all accesses are whole words.
  logic          unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  // A requester whose ack is high this cycle is still holding req from the
  // finished transaction; that req must not start a second one.
  assign if_elig = bus.if_req & ~if_ack_q;
  assign d_elig  = bus.d_req  & ~d_ack_q;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant decisions
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && d_elig) begin
          // Contention: the port that did not win last time goes first.
          if (last_grant == OWN_D) begin
            grant_if = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
        end else if (if_elig) begin
          grant_if = 1'b1;
        end else if (d_elig) begin
          grant_d = 1'b1;
        end

        if (grant_if || (grant_d && !bus.d_we)) begin
          state_next = READ;
        end else if (grant_d) begin
          state_next = WRITE;
        end
      end
      READ: begin
        // cnt is loaded with RD_LAT at the grant edge, so reaching 1 here
        // means this edge is grant + RD_LAT: mem_rdata is valid now.
        if (cnt == 3'd1) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latched request, memory pins, read capture and acks
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner       <= OWN_IF;
      last_grant  <= OWN_D;
      cnt         <= 3'd0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      // Acks are single-cycle pulses.
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;

      if (grant_if) begin
        owner       <= OWN_IF;
        last_grant  <= OWN_IF;
        mem_raddr_q <= {bus.if_addr[AW-1:2], 2'b00};
        cnt         <= 3'(RD_LAT);
      end

      if (grant_d) begin
        owner      <= OWN_D;
        last_grant <= OWN_D;
        if (bus.d_we) begin
          mem_waddr_q <= {bus.d_addr[AW-1:2], 2'b00};
          mem_wdata_q <= bus.d_wdata;
          mem_wr_q    <= 1'b1;
        end else begin
          mem_raddr_q <= {bus.d_addr[AW-1:2], 2'b00};
          cnt         <= 3'(RD_LAT);
        end
      end

      if (state == READ) begin
        cnt <= cnt - 3'd1;
      end

      if (rd_done) begin
        if (owner == OWN_IF) begin
          if_rdata_q <= bus.mem_rdata;
          if_ack_q   <= 1'b1;
        end else begin
          d_rdata_q <= bus.mem_rdata;
          d_ack_q   <= 1'b1;
        end
      end

      // The memory commits the write on the edge that leaves WRITE.
      if (state == WRITE) begin
        mem_wr_q <= 1'b0;
        d_ack_q  <= 1'b1;
      end
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic clk;
  logic nrst;
  logic mem_clr;

  int passed;
  int failed;
  int total;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut1 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus1)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory for dut1: read data follows mem_raddr within the cycle (RD_LAT=1).
  logic [31:0] mem1 [0:63];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem1[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus1.mem_wr) begin
      mem1[bus1.mem_waddr[7:2]] <= bus1.mem_wdata;
    end
  end
  assign bus1.mem_rdata = mem1[bus1.mem_raddr[7:2]];

  // Memory for dut3: two extra register stages (RD_LAT=3).
  logic [31:0] mem3 [0:63];
  logic [31:0] r3_a;
  logic [31:0] r3_b;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem3[i] <= 32'hB000_0000 + 32'(i);
    end else if (bus3.mem_wr) begin
      mem3[bus3.mem_waddr[7:2]] <= bus3.mem_wdata;
    end
    r3_a <= mem3[bus3.mem_raddr[7:2]];
    r3_b <= r3_a;
  end
  assign bus3.mem_rdata = r3_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_if;
  int n_d;
  int n_acks;
  int consec;
  int last_port;
  int first_port;

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    nrst    = 1'b0;
    mem_clr = 1'b1;
    bus1.if_req = 1'b0; bus1.if_addr = '0;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;

    step();
    step();
    check("rst_if_ack",    {31'b0, bus1.if_ack}, 32'h0);
    check("rst_d_ack",     {31'b0, bus1.d_ack},  32'h0);
    check("rst_mem_wr",    {31'b0, bus1.mem_wr}, 32'h0);
    check("rst_mem_raddr", bus1.mem_raddr, 32'h0);
    check("rst_mem_waddr", bus1.mem_waddr, 32'h0);
    check("rst_if_rdata",  bus1.if_rdata,  32'h0);
    check("rst_d_rdata",   bus1.d_rdata,   32'h0);
    check("rst3_mem_raddr", bus3.mem_raddr, 32'h0);
    mem_clr = 1'b0;
    nrst    = 1'b1;

    // Reset abort during WRITE
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h20; bus1.d_wdata = 32'h1111_1111;
    step();
    check("abort_wr_before", {31'b0, bus1.mem_wr}, 32'h1);
    #2 nrst = 1'b0;
    #1;
    check("abort_wr_async", {31'b0, bus1.mem_wr}, 32'h0);
    check("abort_no_ack",   {31'b0, bus1.d_ack},  32'h0);
    bus1.d_req = 1'b0;
    step();
    check("abort_no_ack2", {31'b0, bus1.d_ack}, 32'h0);
    check("abort_mem_untouched", mem1[8], 32'hA000_0008);
    nrst = 1'b1;

    // IF read of 0x4 after reset release
    bus1.if_req = 1'b1; bus1.if_addr = 32'h4;
    step();
    check("if4_raddr", bus1.mem_raddr, 32'h4);
    check("if4_ack_early", {31'b0, bus1.if_ack}, 32'h0);
    step();
    check("if4_ack", {31'b0, bus1.if_ack}, 32'h1);
    check("if4_rdata", bus1.if_rdata, 32'hA000_0001);
    bus1.if_req = 1'b0;
    step();
    check("if4_ack_pulse", {31'b0, bus1.if_ack}, 32'h0);
    check("if4_rdata_held", bus1.if_rdata, 32'hA000_0001);

    // D write 0xDEADBEEF to 0x10
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h10; bus1.d_wdata = 32'hDEAD_BEEF;
    step();
    check("wr_mem_wr",    {31'b0, bus1.mem_wr}, 32'h1);
    check("wr_mem_waddr", bus1.mem_waddr, 32'h10);
    check("wr_mem_wdata", bus1.mem_wdata, 32'hDEAD_BEEF);
    check("wr_ack_early", {31'b0, bus1.d_ack}, 32'h0);
    step();
    check("wr_mem_wr_off", {31'b0, bus1.mem_wr}, 32'h0);
    check("wr_d_ack",      {31'b0, bus1.d_ack},  32'h1);
    bus1.d_req = 1'b0;
    step();
    check("wr_d_ack_pulse", {31'b0, bus1.d_ack}, 32'h0);
    check("wr_mem_written", mem1[4], 32'hDEAD_BEEF);

    // D read of unaligned 0x13 -> word 0x10
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h13;
    step();
    check("rd13_raddr_aligned", bus1.mem_raddr, 32'h10);
    check("rd13_no_wr", {31'b0, bus1.mem_wr}, 32'h0);
    step();
    check("rd13_ack", {31'b0, bus1.d_ack}, 32'h1);
    check("rd13_rdata", bus1.d_rdata, 32'hDEAD_BEEF);
    bus1.d_req = 1'b0;
    step();

    // Tie straight after reset: IF first, then D
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    bus1.if_req = 1'b1; bus1.if_addr = 32'hC;
    bus1.d_req  = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h8;
    step();
    check("tie1_if_first", bus1.mem_raddr, 32'hC);
    step();
    check("tie1_if_ack", {31'b0, bus1.if_ack}, 32'h1);
    check("tie1_if_rdata", bus1.if_rdata, 32'hA000_0003);
    bus1.if_req = 1'b0;
    step();
    check("tie1_d_second", bus1.mem_raddr, 32'h8);
    check("tie1_if_ack_off", {31'b0, bus1.if_ack}, 32'h0);
    step();
    check("tie1_d_ack", {31'b0, bus1.d_ack}, 32'h1);
    check("tie1_d_rdata", bus1.d_rdata, 32'hA000_0002);
    bus1.d_req = 1'b0;
    step();

    // Second tie: last grant was D, so IF wins again
    bus1.if_req = 1'b1; bus1.if_addr = 32'h14;
    bus1.d_req  = 1'b1; bus1.d_addr = 32'h18;
    step();
    check("tie2_if_first", bus1.mem_raddr, 32'h14);
    step();
    check("tie2_if_ack", {31'b0, bus1.if_ack}, 32'h1);
    bus1.if_req = 1'b0;
    step();
    check("tie2_d_second", bus1.mem_raddr, 32'h18);
    step();
    check("tie2_d_rdata", bus1.d_rdata, 32'hA000_0006);
    bus1.d_req = 1'b0;
    step();

    // Fairness: both held for 8 transactions
    bus1.if_req = 1'b1; bus1.if_addr = 32'h0;
    bus1.d_req  = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h4;
    n_if = 0; n_d = 0; n_acks = 0; consec = 0; last_port = -1; first_port = -1;
    for (int c = 0; c < 200 && n_acks < 8; c++) begin
      step();
      if (bus1.if_ack) begin
        if (last_port == 0) consec++;
        if (first_port < 0) first_port = 0;
        last_port = 0;
        n_if++;
        n_acks++;
      end
      if (bus1.d_ack) begin
        if (last_port == 1) consec++;
        if (first_port < 0) first_port = 1;
        last_port = 1;
        n_d++;
        n_acks++;
      end
    end
    bus1.if_req = 1'b0;
    bus1.d_req  = 1'b0;
    check("fair_total",   32'(n_acks), 32'd8);
    check("fair_if",      32'(n_if),   32'd4);
    check("fair_d",       32'(n_d),    32'd4);
    check("fair_consec",  32'(consec), 32'd0);
    check("fair_first_if", 32'(first_port), 32'd0);
    step();
    step();

    // RD_LAT=3: address change mid-READ ignored, data sampled at E3
    bus3.if_req = 1'b1; bus3.if_addr = 32'h24;
    step();
    check("lat3_raddr", bus3.mem_raddr, 32'h24);
    bus3.if_addr = 32'h30;
    step();
    check("lat3_no_ack_e1", {31'b0, bus3.if_ack}, 32'h0);
    check("lat3_raddr_hold1", bus3.mem_raddr, 32'h24);
    step();
    check("lat3_no_ack_e2", {31'b0, bus3.if_ack}, 32'h0);
    check("lat3_raddr_hold2", bus3.mem_raddr, 32'h24);
    step();
    check("lat3_ack_e3", {31'b0, bus3.if_ack}, 32'h1);
    check("lat3_rdata", bus3.if_rdata, 32'hB000_0009);
    bus3.if_req = 1'b0;
    step();
    check("lat3_ack_pulse", {31'b0, bus3.if_ack}, 32'h0);
    check("lat3_rdata_held", bus3.if_rdata, 32'hB000_0009);
    check("lat3_raddr_idle_hold", bus3.mem_raddr, 32'h24);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
